// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the pipeline WB stage
// and the multi-cycle MUL/DIV unit (MDU). The WB stage has priority and no
// handshake. MDU results arrive over a valid/ready handshake into a 2-entry
// FIFO. A result that has waited MAX_WAIT cycles at the FIFO head forces a
// WB stall so that it can drain. A busy scoreboard marks registers that
// still have an MDU result outstanding, for the hazard unit.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   p_wen/p_rd/p_data     pipeline WB write request (rd==0 is not a request)
//   m_valid/m_rd/m_data   MDU result, accepted when m_ready is high
//   m_ready               FIFO has room for an MDU result
//   issue_valid/issue_rd  MDU op issued; marks issue_rd busy
//   rs1/rs2 -> busy1/2    combinational scoreboard lookups
//   stall_req             WB must hold; p_* are not consumed this cycle
//   rf_wen/waddr/wdata    registered register-file write port
module regfile_wb_arbiter #(
  parameter int unsigned N        = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         p_wen,
  input  logic [4:0]   p_rd,
  input  logic [N-1:0] p_data,
  input  logic         m_valid,
  input  logic [4:0]   m_rd,
  input  logic [N-1:0] m_data,
  output logic         m_ready,
  input  logic         issue_valid,
  input  logic [4:0]   issue_rd,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  output logic         busy1,
  output logic         busy2,
  output logic         stall_req,
  output logic         rf_wen,
  output logic [4:0]   rf_waddr,
  output logic [N-1:0] rf_wdata
);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_PIPE,
    GNT_FIFO
  } grant_e;

  localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);

  // FIFO storage and control
  logic [4:0]   fifo_rd_q   [2];
  logic [N-1:0] fifo_data_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         fifo_empty, fifo_full;
  logic         push, pop;
  logic [4:0]   head_rd;
  logic [N-1:0] head_data;

  // Starvation age of the FIFO head
  logic [3:0]   age_q, age_d;

  // Scoreboard
  logic [31:0]  busy_q, busy_d;

  // Write port
  logic         rf_wen_q, rf_wen_d;
  logic [4:0]   rf_waddr_q, rf_waddr_d;
  logic [N-1:0] rf_wdata_q, rf_wdata_d;

  logic         preq;
  grant_e       grant;

  assign fifo_empty = (count_q == 2'd0);
  assign fifo_full  = (count_q == 2'd2);
  assign m_ready    = !fifo_full;
  assign push       = m_valid && m_ready;
  assign head_rd    = fifo_rd_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  assign preq       = p_wen && (p_rd != 5'd0);
  assign stall_req  = (age_q == AGE_MAX) && !fifo_empty;

  // Grant selection: a starved head beats the pipeline, the pipeline beats a
  // fresh head. A push this cycle only becomes visible via count_q next cycle,
  // so there is no bypass from m_* to the write port.
  always_comb begin
    grant = GNT_IDLE;
    if (stall_req) begin
      grant = GNT_FIFO;
    end else if (preq) begin
      grant = GNT_PIPE;
    end else if (!fifo_empty) begin
      grant = GNT_FIFO;
    end
  end

  assign pop = (grant == GNT_FIFO);

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Age: counts cycles the head sits un-popped, saturating at MAX_WAIT
  always_comb begin
    age_d = age_q;
    if (pop || fifo_empty) begin
      age_d = '0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + 4'd1;
    end
  end

  // Scoreboard: clear on the retiring pop, then apply the issue so that a
  // same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (pop && (head_rd != 5'd0)) begin
      busy_d[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Write port next state; address/data hold on idle and rd=0 pops
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (grant)
      GNT_PIPE: begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = p_rd;
        rf_wdata_d = p_data;
      end
      GNT_FIFO: begin
        if (head_rd != 5'd0) begin
          rf_wen_d   = 1'b1;
          rf_waddr_d = head_rd;
          rf_wdata_d = head_data;
        end
      end
      default: begin
        rf_wen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      age_q      <= '0;
      busy_q     <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      age_q      <= age_d;
      busy_q     <= busy_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= m_rd;
      fifo_data_q[wr_ptr_q] <= m_data;
    end
  end

  assign busy1    = busy_q[rs1];
  assign busy2    = busy_q[rs2];
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic        p_wen;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        busy1;
  logic        busy2;
  logic        stall_req;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  regfile_wb_arbiter #(.N(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .p_wen(p_wen), .p_rd(p_rd), .p_data(p_data),
    .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .busy1(busy1), .busy2(busy2),
    .stall_req(stall_req),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: pending MDU results as queues, plain integer age
  logic [4:0]  mq_rd[$];
  logic [31:0] mq_data[$];
  int          m_age = 0;
  bit          mbusy[32];
  bit          model_ok = 0;
  logic        e_wen = 0;
  logic [4:0]  e_waddr = 0;
  logic [31:0] e_wdata = 0;
  bit          m_stall_last;
  bit          m_pushed;
  logic        obs_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    int sz;
    bit preq;
    bit popped;
    logic [4:0]  r;
    logic [31:0] d;
    #1;
    sz = mq_rd.size();
    m_stall_last = model_ok && (m_age == MAX_WAIT) && (sz > 0);
    obs_stall = stall_req;
    if (model_ok) begin
      chk("m_ready",   32'(m_ready),   32'(sz < 2));
      chk("stall_req", 32'(stall_req), 32'(m_stall_last));
      chk("busy1",     32'(busy1),     32'(mbusy[rs1]));
      chk("busy2",     32'(busy2),     32'(mbusy[rs2]));
    end
    m_pushed = 0;
    if (reset) begin
      mq_rd.delete();
      mq_data.delete();
      m_age = 0;
      for (int i = 0; i < 32; i++) mbusy[i] = 0;
      e_wen = 0; e_waddr = 0; e_wdata = 0;
      model_ok = 1;
    end else begin
      preq = p_wen && (p_rd != 0);
      popped = 0;
      e_wen = 0;
      if (m_stall_last || (!preq && sz > 0)) begin
        r = mq_rd.pop_front();
        d = mq_data.pop_front();
        popped = 1;
        if (r != 0) begin
          e_wen = 1; e_waddr = r; e_wdata = d;
          mbusy[r] = 0;
        end
      end else if (preq) begin
        e_wen = 1; e_waddr = p_rd; e_wdata = p_data;
      end
      if (popped || sz == 0) m_age = 0;
      else if (m_age < MAX_WAIT) m_age = m_age + 1;
      if (m_valid && sz < 2) begin
        mq_rd.push_back(m_rd);
        mq_data.push_back(m_data);
        m_pushed = 1;
      end
      if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1;
    end
    @(posedge clk);
    #1;
    if (model_ok) begin
      chk("rf_wen",   32'(rf_wen),   32'(e_wen));
      chk("rf_waddr", 32'(rf_waddr), 32'(e_waddr));
      chk("rf_wdata", rf_wdata,      e_wdata);
    end
  endtask

  task automatic idle_inputs();
    p_wen = 0; p_rd = 0; p_data = 0;
    m_valid = 0; m_rd = 0; m_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  initial begin
    int stall_cnt;
    int stage;
    int prd;
    reset = 1; rs1 = 0; rs2 = 0;
    idle_inputs();

    // Reset, then idle while sweeping every scoreboard address
    tick(); tick();
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      tick();
      chk("rst_busy1", 32'(busy1), 32'd0);
    end
    chk("rst_m_ready", 32'(m_ready), 32'd1);

    // Pipeline-only writes
    p_wen = 1; p_rd = 5; p_data = 32'hDEADBEEF;
    tick();
    chk("pipe_waddr", 32'(rf_waddr), 32'd5);
    chk("pipe_wdata", rf_wdata, 32'hDEADBEEF);
    p_rd = 0;
    tick();
    chk("pipe_rd0_wen", 32'(rf_wen), 32'd0);
    idle_inputs();

    // MDU path with scoreboard
    issue_valid = 1; issue_rd = 7; rs1 = 7;
    tick();
    issue_valid = 0;
    tick();
    m_valid = 1; m_rd = 7; m_data = 42;
    tick();
    chk("mdu_no_bypass", 32'(rf_wen), 32'd0);
    m_valid = 0;
    tick();
    chk("mdu_wen", 32'(rf_wen), 32'd1);
    chk("mdu_waddr", 32'(rf_waddr), 32'd7);
    chk("mdu_wdata", rf_wdata, 32'd42);
    tick();
    chk("mdu_busy_clr", 32'(busy1), 32'd0);

    // Starvation: pipeline writes every cycle, pipeline holds on stall
    stall_cnt = 0;
    prd = 1;
    p_wen = 1; p_rd = 1; p_data = 32'h100;
    m_valid = 1; m_rd = 3; m_data = 32'h33;
    tick();
    m_valid = 0;
    for (int i = 0; i < 9; i++) begin
      if (!m_stall_last) begin
        prd++;
        p_rd = 5'(prd); p_data = 32'h100 + 32'(prd);
      end
      tick();
      if (obs_stall) begin
        stall_cnt++;
        chk("stall_grant_rd", 32'(rf_waddr), 32'd3);
      end
    end
    chk("stall_cycles", 32'(stall_cnt), 32'd1);
    idle_inputs();
    tick();

    // FIFO full under continuous pipeline traffic, order 10, 11, 12
    stage = 0;
    prd = 20;
    p_wen = 1; p_rd = 20; p_data = 32'h200;
    for (int i = 0; i < 30; i++) begin
      m_valid = (stage < 3);
      m_rd = 5'(10 + stage);
      m_data = 32'hA00 + 32'(stage);
      tick();
      if (m_pushed) stage++;
      if (!m_stall_last) begin
        prd = (prd == 29) ? 20 : prd + 1;
        p_rd = 5'(prd); p_data = 32'h200 + 32'(prd);
      end
    end
    chk("fifo_full_accept", 32'(stage), 32'd3);
    idle_inputs();
    repeat (4) tick();

    // Same-cycle set and clear of register 9: set wins
    issue_valid = 1; issue_rd = 9; rs1 = 9;
    tick();
    issue_valid = 0;
    m_valid = 1; m_rd = 9; m_data = 32'h99;
    tick();
    m_valid = 0;
    issue_valid = 1; issue_rd = 9;
    tick();
    chk("setclr_waddr", 32'(rf_waddr), 32'd9);
    issue_valid = 0;
    tick();
    chk("setclr_busy", 32'(busy1), 32'd1);

    // Reset with two entries buffered discards them
    issue_valid = 1; issue_rd = 13; rs2 = 13;
    p_wen = 1; p_rd = 1; p_data = 32'h1;
    m_valid = 1; m_rd = 13; m_data = 32'h13;
    tick();
    issue_valid = 0;
    m_rd = 14; m_data = 32'h14;
    tick();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_mid_wen", 32'(rf_wen), 32'd0);
    end
    chk("rst_mid_busy", 32'(busy2), 32'd0);
    chk("rst_mid_ready", 32'(m_ready), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      p_wen       = 1'($urandom_range(0, 1));
      p_rd        = 5'($urandom_range(0, 7));
      p_data      = $urandom;
      m_valid     = 1'($urandom_range(0, 1));
      m_rd        = 5'($urandom_range(0, 7));
      m_data      = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 31));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writers: the pipeline WB stage (fixed priority, no handshake) and the multi-cycle MUL/DIV unit (MDU, valid/ready handshake).
- Buffers MDU results in a 2-entry FIFO.
- Forces a pipeline stall if an MDU result has waited too long.
- Keeps a busy scoreboard of registers with an MDU result still outstanding, for the hazard unit.

Parameters:
- N, 32, data width
- MAX_WAIT, 4, cycles an MDU result may wait at the FIFO head before stall_req is asserted (range 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- p_wen  in  1  pipeline WB write request
- p_rd  in  5  pipeline destination register
- p_data  in  N  pipeline write data
- m_valid  in  1  MDU result valid
- m_rd  in  5  MDU destination register
- m_data  in  N  MDU result
- m_ready  out  1  FIFO can accept an MDU result
- issue_valid  in  1  MDU operation issued this cycle
- issue_rd  in  5  destination register of the issued MDU operation
- rs1  in  5  scoreboard query address 1
- rs2  in  5  scoreboard query address 2
- busy1  out  1  busy[rs1], combinational
- busy2  out  1  busy[rs2], combinational
- stall_req  out  1  WB stage must hold; the arbiter does not consume p_* this cycle
- rf_wen  out  1  register-file write enable, registered
- rf_waddr  out  5  register-file write address, registered
- rf_wdata  out  N  register-file write data, registered

Behaviour:
- Reset (synchronous, clk rising edge while reset=1) clears:
  - FIFO (empty, pointers 0)
  - age counter
  - busy[31:0]
  - rf_wen, rf_waddr, rf_wdata
  - stall_req
- After reset, m_ready=1.
- Reset mid-operation discards buffered results with no write.
- Request qualification:
  - Pipeline request: preq = p_wen && p_rd!=0.
  - MDU entries with rd=0 are popped with no write (rf_wen=0).
- FIFO:
  - 2 entries of {rd, data}.
  - m_ready = !full.
  - Push on m_valid && m_ready.
  - Simultaneous push and pop when full is not allowed, since m_ready is already 0.
  - Push and pop in the same cycle when it holds 1 entry are allowed; count stays 1.
  - Push into an empty FIFO is not poppable until the next cycle; there is no bypass.
- Age counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on every pop and whenever the FIFO is empty.
  - Saturates at MAX_WAIT.
- stall_req = (age == MAX_WAIT) && FIFO non-empty. This is combinational from registered state.
- Arbitration, one grant per cycle:
  1. stall_req=1: grant the FIFO head. p_* are ignored; the pipeline holds them and represents them later.
  2. Otherwise, if preq: grant the pipeline.
  3. Otherwise, if the FIFO is non-empty: grant the FIFO head.
  4. Otherwise: idle.
- Output latency: the grant is registered. On the next edge rf_wen/rf_waddr/rf_wdata take the granted values, giving 1-cycle latency from request to register-file write enable.
  - Idle cycle or rd=0 pop: rf_wen=0; rf_waddr and rf_wdata hold their last value.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets busy[issue_rd].
  - A FIFO pop with rd!=0 clears busy[rd] at the same edge rf_wen is registered.
  - Set and clear of the same register in the same cycle: set wins.
  - Pipeline writes never touch busy; the hazard unit prevents WAW on busy registers.
  - busy[0] is always 0.
- Invariants:
  - At most one write per cycle.
  - A result is never dropped or duplicated.
  - MDU results are written in arrival order.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> rf_wen=0, m_ready=1, stall_req=0, busy1=busy2=0 for all rs.
- Pipeline only: p_wen=1, p_rd=5, p_data=0xDEADBEEF -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Same stimulus with p_rd=0 -> rf_wen=0.
- MDU path with scoreboard:
  - issue_valid, issue_rd=7 -> busy[7]=1.
  - m_valid, m_rd=7, m_data=42 with p_wen=0 -> written 2 cycles after push (push cycle, then pop cycle, then register); busy[7] clears on that edge.
- Conflict and starvation (MAX_WAIT=4):
  - Push m_rd=3 while p_wen=1 each cycle to rd 1,2,3,4,...
  - Pipeline writes for 4 cycles, then stall_req=1 for exactly 1 cycle.
  - Next rf_waddr=3. The held pipeline write then follows.
- FIFO full: two MDU pushes while the pipeline writes continuously -> m_ready=0; a third m_valid is not accepted until a pop. Order is preserved (rd 10 then 11).
- Simultaneous set/clear: issue_rd=9 in the same cycle a FIFO pop writes rd 9 -> busy[9]=1 afterwards. Assert reset with 2 entries buffered -> no writes, FIFO empty, busy=0.
